// File: rtl/updown_register.sv
// ============================================================================
//  Module   : updown_register
//  Brief    : Up/down/load/clear register with wrap-or-saturate limits and
//             optional serial shift (enabled by UPDOWN_REGISTER_SHIFT_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_register #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
   parameter bit               WRAP      = 1'b1
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic             en,
   input  logic [2:0]       ctrl,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             zero,
   output logic             at_max,
   output logic             tc,
   output logic             range_err
);

   localparam logic [2:0]       c_OP_INCR = 3'd1;
   localparam logic [2:0]       c_OP_DECR = 3'd2;
   localparam logic [2:0]       c_OP_LOAD = 3'd3;
   localparam logic [2:0]       c_OP_CLR  = 3'd4;
`ifdef UPDOWN_REGISTER_SHIFT_EN
   localparam logic [2:0]       c_OP_SHL  = 3'd5;
   localparam logic [2:0]       c_OP_SHR  = 3'd6;
`endif
   localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_ZERO    = '0;

   logic [WIDTH-1:0] r_value;
   logic             r_tc;
   logic             r_range_err;

   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_cand;
   logic             w_clamp_chk;
   logic             w_tc;
   logic             w_range_err;

   // LOAD and shifts produce a candidate that is limit-checked in one place.
   always_comb begin
      w_next      = r_value;
      w_cand      = c_ZERO;
      w_clamp_chk = 1'b0;
      w_tc        = 1'b0;
      w_range_err = 1'b0;
      case (ctrl)
         c_OP_INCR: begin
            if (r_value == MAX_VALUE) begin
               w_tc   = 1'b1;
               w_next = WRAP ? c_ZERO : MAX_VALUE;
            end else begin
               w_next = r_value + c_ONE;
            end
         end
         c_OP_DECR: begin
            if (r_value == c_ZERO) begin
               w_tc   = 1'b1;
               w_next = WRAP ? MAX_VALUE : c_ZERO;
            end else begin
               w_next = r_value - c_ONE;
            end
         end
         c_OP_LOAD: begin
            w_cand      = data_in;
            w_clamp_chk = 1'b1;
         end
         c_OP_CLR: begin
            w_next = c_ZERO;
         end
`ifdef UPDOWN_REGISTER_SHIFT_EN
         c_OP_SHL: begin
            w_cand      = {r_value[WIDTH-2:0], data_in[0]};
            w_clamp_chk = 1'b1;
         end
         c_OP_SHR: begin
            w_cand      = {data_in[WIDTH-1], r_value[WIDTH-1:1]};
            w_clamp_chk = 1'b1;
         end
`endif
         default: begin
         end
      endcase

      if (w_clamp_chk) begin
         if (w_cand > MAX_VALUE) begin
            w_next      = MAX_VALUE;
            w_range_err = 1'b1;
         end else begin
            w_next = w_cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_value     <= c_ZERO;
         r_tc        <= 1'b0;
         r_range_err <= 1'b0;
      end else if (en) begin
         r_value     <= w_next;
         r_tc        <= w_tc;
         r_range_err <= w_range_err;
      end else begin
         r_tc        <= 1'b0;
         r_range_err <= 1'b0;
      end
   end

   assign data_out  = r_value;
   assign zero      = (r_value == c_ZERO);
   assign at_max    = (r_value == MAX_VALUE);
   assign tc        = r_tc;
   assign range_err = r_range_err;

endmodule

`default_nettype wire

// File: tb/tb_updown_register.sv
// ============================================================================
//  Module   : tb_updown_register
//  Brief    : Directed + random bench for updown_register, three configurations
//             driven in lockstep against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_register;

`ifdef UPDOWN_REGISTER_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   localparam int NONE = 0, INCR = 1, DECR = 2, LOAD = 3, CLR = 4, SHL = 5, SHR = 6;

   // Instance 0: W4/M9/wrap, 1: W4/M9/saturate, 2: W8/M255/wrap
   int cfg_w    [3] = '{4, 4, 8};
   int cfg_max  [3] = '{9, 9, 255};
   int cfg_wrap [3] = '{1, 0, 1};

   logic       clk;
   logic       sync_reset;
   logic       en;
   logic [2:0] ctrl;
   logic [7:0] din;

   logic [3:0] q0, q1;
   logic [7:0] q2;
   logic       z0, z1, z2, m0, m1, m2, t0, t1, t2, e0, e1, e2;

   int m_val [3];
   int m_tc  [3];
   int m_re  [3];

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   updown_register #(.WIDTH(4), .MAX_VALUE(4'd9), .WRAP(1'b1)) u_wrap4 (
      .clk(clk), .sync_reset(sync_reset), .en(en), .ctrl(ctrl), .data_in(din[3:0]),
      .data_out(q0), .zero(z0), .at_max(m0), .tc(t0), .range_err(e0));

   updown_register #(.WIDTH(4), .MAX_VALUE(4'd9), .WRAP(1'b0)) u_sat4 (
      .clk(clk), .sync_reset(sync_reset), .en(en), .ctrl(ctrl), .data_in(din[3:0]),
      .data_out(q1), .zero(z1), .at_max(m1), .tc(t1), .range_err(e1));

   updown_register #(.WIDTH(8)) u_wrap8 (
      .clk(clk), .sync_reset(sync_reset), .en(en), .ctrl(ctrl), .data_in(din),
      .data_out(q2), .zero(z2), .at_max(m2), .tc(t2), .range_err(e2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference behaviour computed directly from the operation rules.
   task automatic model(input int i, input bit rst, input bit e, input int op, input int d);
      int modv, lim, dv, cand;
      bit chkc;
      modv = 1 << cfg_w[i];
      lim  = cfg_max[i];
      dv   = d % modv;
      cand = 0;
      chkc = 1'b0;
      m_tc[i] = 0;
      m_re[i] = 0;
      if (rst) begin
         m_val[i] = 0;
      end else if (e) begin
         case (op)
            INCR: if (m_val[i] == lim) begin
                     m_tc[i]  = 1;
                     m_val[i] = cfg_wrap[i] ? 0 : lim;
                  end else m_val[i] = m_val[i] + 1;
            DECR: if (m_val[i] == 0) begin
                     m_tc[i]  = 1;
                     m_val[i] = cfg_wrap[i] ? lim : 0;
                  end else m_val[i] = m_val[i] - 1;
            LOAD: begin cand = dv; chkc = 1'b1; end
            CLR:  m_val[i] = 0;
            SHL:  if (SHIFT_EN) begin
                     cand = (m_val[i] * 2) % modv + (dv % 2);
                     chkc = 1'b1;
                  end
            SHR:  if (SHIFT_EN) begin
                     cand = m_val[i] / 2 + ((dv / (modv / 2)) % 2) * (modv / 2);
                     chkc = 1'b1;
                  end
            default: ;
         endcase
         if (chkc) begin
            if (cand > lim) begin
               m_val[i] = lim;
               m_re[i]  = 1;
            end else m_val[i] = cand;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] q [3];
      logic       z [3], m [3], t [3], r [3];
      q = '{{4'd0, q0}, {4'd0, q1}, q2};
      z = '{z0, z1, z2};
      m = '{m0, m1, m2};
      t = '{t0, t1, t2};
      r = '{e0, e1, e2};
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s u%0d data_out", tag, i), 32'(q[i]), 32'(m_val[i]));
         chk($sformatf("%s u%0d zero", tag, i), 32'(z[i]), 32'(m_val[i] == 0));
         chk($sformatf("%s u%0d at_max", tag, i), 32'(m[i]), 32'(m_val[i] == cfg_max[i]));
         chk($sformatf("%s u%0d tc", tag, i), 32'(t[i]), 32'(m_tc[i]));
         chk($sformatf("%s u%0d range_err", tag, i), 32'(r[i]), 32'(m_re[i]));
      end
   endtask

   task automatic step(input string tag, input bit rst, input bit e, input int op, input int d);
      sync_reset = rst;
      en         = e;
      ctrl       = 3'(op);
      din        = 8'(d);
      @(posedge clk);
      for (int i = 0; i < 3; i++) model(i, rst, e, op, d);
      #1;
      check_all(tag);
   endtask

   initial begin
      sync_reset = 1'b1;
      en         = 1'b0;
      ctrl       = 3'd0;
      din        = 8'd0;
      for (int i = 0; i < 3; i++) begin
         m_val[i] = 0; m_tc[i] = 0; m_re[i] = 0;
      end
      @(negedge clk);

      step("reset", 1, 0, NONE, 0);

      // Terminal count at MAX with wrap / saturate, single-cycle pulse
      step("load9", 0, 1, LOAD, 9);
      step("incr_at_max", 0, 1, INCR, 0);
      step("incr_at_max_rep", 0, 1, INCR, 0);
      step("none_after_tc", 0, 1, NONE, 0);

      // Underflow: repeated DECR at zero
      step("clr", 0, 1, CLR, 0);
      step("decr_a", 0, 1, DECR, 0);
      step("decr_b", 0, 1, DECR, 0);
      step("decr_c", 0, 1, DECR, 0);

      // Out-of-range load clamps
      step("load13", 0, 1, LOAD, 13);
      step("after_clamp", 0, 1, NONE, 0);

      // Shift (effective only with shift logic built in)
      step("load81", 0, 1, LOAD, 8'h81);
      step("shl", 0, 1, SHL, 8'h01);
      step("shr", 0, 1, SHR, 8'h00);
      step("reserved7", 0, 1, 7, 8'hFF);

      // Hold with en low, then reset overriding a LOAD
      step("load5", 0, 1, LOAD, 5);
      for (int k = 0; k < 4; k++) step("hold_en0", 0, 0, INCR, 0);
      step("rst_over_load", 1, 1, LOAD, 7);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         bit rr, ee;
         rr = ($urandom_range(0, 19) == 0);
         ee = ($urandom_range(0, 3) != 0);
         step("rand", rr, ee, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
